keypad_scan: RTL
================

Name: keypad_scan

Overview:
- Matrix-keypad front end for the lock.
- Drives the rows of a 4x3 membrane keypad and samples its columns, then debounces the result.
- Output is the one-hot 12-bit `Key` code that the lock controller (`top_1`) consumes.
- `Key` holds the code while the key stays down and returns to all-zero ("None") on release. `key_valid` marks each new press.

Parameters:
- SCAN_DIV, 50000, clocks per scan tick (row dwell time); minimum 4.
- DEBOUNCE_TICKS, 4, consecutive identical tick samples needed to accept a press or a release; minimum 1.
- REPEAT_TICKS, 100, ticks between auto-repeat pulses; used only with the optional feature.

Ports:
- clock, input, 1, system clock; all logic is on the rising edge.
- reset, input, 1, synchronous active-low reset.
- row, output, 4, active-low row drive; exactly one bit low at any time.
- col, input, 3, active-low column sense with external pull-ups; asynchronous to `clock`.
- Key, output, 12, one-hot key code; 0 = no key.
- key_valid, output, 1, one-clock pulse when `Key` takes a new non-zero value.

Behaviour:
- Key encoding: matrix index = row*3 + col, and `Key` bit = index.
  - Row0 = 1,2,3 → bits 0,1,2. Row1 = 4,5,6 → bits 3,4,5. Row2 = 7,8,9 → bits 6,7,8.
  - Row3 = `*`,0,`#` → bits 9,10,11.
- Synchronizer: `col` passes through 2 flops before any use.
- Tick divider: counts 0..SCAN_DIV-1. `tick` is high for one clock when the count is SCAN_DIV-1, then the count wraps to 0. The divider runs in every state.
- Column samples are taken only on `tick`, so each row has settled for a full period before it is read.
- State machine: SCAN, DEBOUNCE, PRESSED, RELEASE.
- SCAN:
  - On `tick`, if the synced col has exactly one bit low: latch row index and col index, set debounce count = 1, go to DEBOUNCE. If DEBOUNCE_TICKS = 1, go straight to PRESSED.
  - Otherwise advance `row` to the next row: 1110 → 1101 → 1011 → 0111 → 1110.
  - Zero or several low columns are treated as "none".
- DEBOUNCE (row drive frozen):
  - On `tick`, if col equals the latched single-low pattern, increment the count. Reaching DEBOUNCE_TICKS → PRESSED.
  - Any other pattern returns to SCAN and advances the row. No output is produced.
- PRESSED entry: `Key` is set to the one-hot code and `key_valid` pulses for one clock, both in the same clock as the transition.
- PRESSED (row frozen, `Key` held):
  - On `tick`, all col high sets release count = 1 and goes to RELEASE.
  - Any pattern other than all-high, including a second key on the same row, is ignored and `Key` is unchanged.
- RELEASE:
  - On `tick`, all col high increments the count. Reaching DEBOUNCE_TICKS sets `Key` = 0, goes to SCAN and advances the row.
  - If the original pattern reappears, return to PRESSED with no new `key_valid`.
- Latency from a stable press to `key_valid`: at most 4*SCAN_DIV + DEBOUNCE_TICKS*SCAN_DIV + 3 clocks.
- Reset values: `row` = 4'b1110, `Key` = 0, `key_valid` = 0, state = SCAN, all counters 0, synchronizer flops = 3'b111. Reset has priority in every state.
- Reset mid-press: outputs clear the next clock. A key still held after reset is detected again as a new press.
- Keys on other rows are invisible while a row is frozen. Only the first accepted key is reported.
- At most one bit of `Key` is ever set.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter counts ticks from PRESSED entry.
  - At REPEAT_TICKS it re-pulses `key_valid` with `Key` unchanged and restarts the count.
  - The counter clears on leaving PRESSED. A return from RELEASE restarts it at 0.
- Not defined: no repeat counter is built and `key_valid` fires once per press.

Test Plan (SCAN_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5):
1. Reset low for 3 clocks, then high, no key held → `row` cycles 1110, 1101, 1011, 0111, changing every 4 clocks; `Key` = 0; `key_valid` = 0 throughout.
2. Press "2" (col[1] low only while row[0] low), hold for 200 clocks, then release → one `key_valid` pulse with `Key` = 12'h002. `Key` holds 12'h002 until 3 release ticks after col goes high, then returns to 0.
3. Press "#" (row[3], col[2]) with 1-tick bounces during debounce, then stable → no output during bounces; after stable, `Key` = 12'h800 with exactly one `key_valid`.
4. Two columns low on the same row (e.g. "4" + "5") → treated as none; `Key` stays 0 and scanning continues.
5. Sequence "2","4","3","2","*" with a release between each key → `Key` values 002, 008, 004, 002, 200 (hex), with exactly 5 `key_valid` pulses. Drive into `top_1` and check it accepts the code.
6. Hold "0" (12'h400) and assert reset low for 1 clock mid-press → `Key` = 0 on the next clock, then 12'h400 reappears after re-scan with a new `key_valid`.
   - With KEY_REPEAT_EN defined: holding the key for 30 ticks gives repeat pulses every 5 ticks after entry.

Source files
------------

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//   Matrix-keypad front end for the lock. It walks a single low bit across the
//   four active-low rows of a 4x3 membrane keypad, samples the three pulled-up
//   column lines once per scan tick, debounces presses and releases, and
//   presents a one-hot 12-bit key code to the lock controller.
//
//   Key encoding: bit index = row*3 + col
//     row0: 1 2 3 -> bits 0..2    row1: 4 5 6 -> bits 3..5
//     row2: 7 8 9 -> bits 6..8    row3: * 0 # -> bits 9..11
//
//   Optional feature (compile-time macro KEY_REPEAT_EN):
//     while a key stays down, key_valid re-pulses every REPEAT_TICKS scan
//     ticks with Key unchanged. Without the macro key_valid fires once per
//     press and no repeat counter is built.
//
// Parameters:
//   SCAN_DIV       clocks per scan tick (row dwell time), >= 4
//   DEBOUNCE_TICKS consecutive identical tick samples to accept press/release
//   REPEAT_TICKS   ticks between auto-repeat pulses (KEY_REPEAT_EN only)
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-low reset
//   row[3:0]   active-low row drive, exactly one bit low
//   col[2:0]   active-low column sense, asynchronous to clock
//   Key[11:0]  one-hot key code, 0 = no key
//   key_valid  one-clock pulse when Key takes a new non-zero value
//   state_o    current scan state (debug view of the FSM)
//
// Handshake: key_valid is a single-cycle strobe with no ready; Key is valid in
// the same cycle as the strobe and stays stable until the key is released.
// -----------------------------------------------------------------------------
module keypad_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_TICKS   = 100
) (
    input  logic        clock,
    input  logic        reset,
    output logic [3:0]  row,
    input  logic [2:0]  col,
    output logic [11:0] Key,
    output logic        key_valid,
    output logic [1:0]  state_o
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         col_s1_q, col_s2_q;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         row_sel_q, row_sel_d;
    logic [1:0]         key_col_q, key_col_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [11:0]        key_q, key_d;
    logic               key_valid_q, key_valid_d;

    logic               tick;
    logic               single_low;
    logic [1:0]         col_idx;
    logic [2:0]         held_pat;
    logic [1:0]         row_next;

`ifdef KEY_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
    logic [RPT_W-1:0]   rpt_q, rpt_d;
`else
    logic               unused_repeat;
    assign unused_repeat = (REPEAT_TICKS > 0);
`endif

    function automatic logic [11:0] onehot_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] idx;
        idx = 4'(r) * 4'd3 + 4'(c);
        return 12'd1 << idx;
    endfunction

    // Scan tick: one clock every SCAN_DIV clocks, free running in all states.
    assign tick  = (div_q == DIV_W'(SCAN_DIV - 1));
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    // Only a single low column counts as a key; zero or several low is "none".
    always_comb begin
        single_low = 1'b1;
        col_idx    = 2'd0;
        case (col_s2_q)
            3'b110:  col_idx = 2'd0;
            3'b101:  col_idx = 2'd1;
            3'b011:  col_idx = 2'd2;
            default: single_low = 1'b0;
        endcase
    end

    // Column pattern of the key being debounced / held.
    assign held_pat = ~(3'b001 << key_col_q);
    assign row_next = row_sel_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        row_sel_d   = row_sel_q;
        key_col_d   = key_col_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
`ifdef KEY_REPEAT_EN
        rpt_d       = '0;
`endif
        case (state_q)
            S_SCAN: begin
                if (tick) begin
                    if (single_low) begin
                        key_col_d = col_idx;
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d     = S_PRESSED;
                            key_d       = onehot_code(row_sel_q, col_idx);
                            key_valid_d = 1'b1;
                            cnt_d       = '0;
                        end else begin
                            state_d = S_DEBOUNCE;
                            cnt_d   = CNT_W'(1);
                        end
                    end else begin
                        row_sel_d = row_next;
                    end
                end
            end

            // Row drive is frozen here: row_sel_q is the row of the candidate key.
            S_DEBOUNCE: begin
                if (tick) begin
                    if (col_s2_q == held_pat) begin
                        if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_TICKS)) begin
                            state_d     = S_PRESSED;
                            key_d       = onehot_code(row_sel_q, key_col_q);
                            key_valid_d = 1'b1;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d   = S_SCAN;
                        row_sel_d = row_next;
                        cnt_d     = '0;
                    end
                end
            end

            // Anything other than all-high (e.g. a second key) is ignored.
            S_PRESSED: begin
`ifdef KEY_REPEAT_EN
                rpt_d = rpt_q;
`endif
                if (tick) begin
                    if (col_s2_q == 3'b111) begin
`ifdef KEY_REPEAT_EN
                        rpt_d = '0;
`endif
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d   = S_SCAN;
                            key_d     = '0;
                            row_sel_d = row_next;
                            cnt_d     = '0;
                        end else begin
                            state_d = S_RELEASE;
                            cnt_d   = CNT_W'(1);
                        end
                    end
`ifdef KEY_REPEAT_EN
                    else if (rpt_q == RPT_W'(REPEAT_TICKS - 1)) begin
                        key_valid_d = 1'b1;
                        rpt_d       = '0;
                    end else begin
                        rpt_d = rpt_q + RPT_W'(1);
                    end
`endif
                end
            end

            // Key is still reported while the release is being confirmed.
            S_RELEASE: begin
                if (tick) begin
                    if (col_s2_q == 3'b111) begin
                        if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_TICKS)) begin
                            state_d   = S_SCAN;
                            key_d     = '0;
                            row_sel_d = row_next;
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (col_s2_q == held_pat) begin
                        // Contact bounce on release: same key, no new strobe.
                        state_d = S_PRESSED;
                        cnt_d   = '0;
                    end
                end
            end

            default: begin
                state_d = S_SCAN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            col_s1_q    <= 3'b111;
            col_s2_q    <= 3'b111;
            div_q       <= '0;
            state_q     <= S_SCAN;
            row_sel_q   <= 2'd0;
            key_col_q   <= 2'd0;
            cnt_q       <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            col_s1_q    <= col;
            col_s2_q    <= col_s1_q;
            div_q       <= div_d;
            state_q     <= state_d;
            row_sel_q   <= row_sel_d;
            key_col_q   <= key_col_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    assign row       = ~(4'b0001 << row_sel_q);
    assign Key       = key_q;
    assign key_valid = key_valid_q;
    assign state_o   = state_q;

endmodule
